// File: rtl/ternary_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : ternary_regfile_sb
// Brief    : Multi-port ternary register file with issue-time scoreboard
//            and optional same-cycle write-to-read bypass.
// Revision : 1.0 - initial release
// ============================================================================
module ternary_regfile_sb #(
    parameter int ADDR_TRITS = 2,
    parameter int NUM_REGS   = 9,
    parameter int TRIT_WIDTH = 27,
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD*ADDR_TRITS*2-1:0] rd_addr,
    output logic [NUM_RD*TRIT_WIDTH*2-1:0] rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR*ADDR_TRITS*2-1:0] wr_addr,
    input  logic [NUM_WR*TRIT_WIDTH*2-1:0] wr_data,
    input  logic [NUM_WR-1:0]              claim_en,
    input  logic [NUM_WR*ADDR_TRITS*2-1:0] claim_addr,
    input  logic                           flush,
    output logic [NUM_REGS-1:0]            busy_vec,
    output logic                           wr_conflict
);

    localparam int c_AW       = ADDR_TRITS * 2;
    localparam int c_DW       = TRIT_WIDTH * 2;
    localparam int c_IDX_SPAN = 3 ** ADDR_TRITS;
    localparam int c_IW       = (c_IDX_SPAN > 2) ? $clog2(c_IDX_SPAN) : 1;

    localparam logic [1:0] c_T_POS_ONE = 2'b01;
    localparam logic [1:0] c_T_NEG_ONE = 2'b10;

    // Out-of-range indices fold onto R0 so they behave like the zero register.
    function automatic logic [c_IW-1:0] decode(input logic [c_AW-1:0] a);
        int acc;
        int wt;
        acc = 0;
        wt  = 1;
        for (int k = 0; k < ADDR_TRITS; k++) begin
            if (a[2*k +: 2] == c_T_POS_ONE)
                acc = acc + wt;
            else if (a[2*k +: 2] == c_T_NEG_ONE)
                acc = acc + 2 * wt;
            wt = wt * 3;
        end
        if (acc >= NUM_REGS)
            acc = 0;
        return c_IW'(acc);
    endfunction

    logic [c_DW-1:0]     r_regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] r_busy;
    logic                r_conflict;

    logic [c_IW-1:0]     w_wr_idx [NUM_WR];
    logic [c_IW-1:0]     w_cl_idx [NUM_WR];
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                w_conflict;

    generate
        for (genvar g = 0; g < NUM_WR; g++) begin : g_wr_dec
            assign w_wr_idx[g] = decode(wr_addr[g*c_AW +: c_AW]);
            assign w_cl_idx[g] = decode(claim_addr[g*c_AW +: c_AW]);
        end
    endgenerate

    // Later claim ports apply last so a claim outranks a same-cycle write.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < NUM_REGS; i++) begin
            for (int j = 0; j < NUM_WR; j++)
                if (wr_en[j] && (w_wr_idx[j] == c_IW'(i)))
                    w_busy_nxt[i] = 1'b0;
            for (int j = 0; j < NUM_WR; j++)
                if (claim_en[j] && (w_cl_idx[j] == c_IW'(i)))
                    w_busy_nxt[i] = 1'b1;
        end
        if (flush)
            w_busy_nxt = '0;
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int j = 0; j < NUM_WR; j++)
            for (int k = j + 1; k < NUM_WR; k++)
                if (wr_en[j] && wr_en[k] && (w_wr_idx[j] == w_wr_idx[k]) &&
                    (w_wr_idx[j] != '0))
                    w_conflict = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++)
                r_regs[i] <= '0;
            r_busy     <= '0;
            r_conflict <= 1'b0;
        end else begin
            // Ascending port order: the highest matching port's assignment lands last.
            for (int i = 1; i < NUM_REGS; i++)
                for (int j = 0; j < NUM_WR; j++)
                    if (wr_en[j] && (w_wr_idx[j] == c_IW'(i)))
                        r_regs[i] <= wr_data[j*c_DW +: c_DW];
            r_busy     <= w_busy_nxt;
            r_conflict <= w_conflict;
        end
    end

    generate
        for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
            logic [c_IW-1:0] w_idx;
            logic [c_DW-1:0] w_data;
            logic            w_busy;
            logic            w_fwd;

            assign w_idx = decode(rd_addr[g*c_AW +: c_AW]);

            always_comb begin
                w_data = '0;
                w_busy = 1'b0;
                w_fwd  = 1'b0;
                for (int i = 1; i < NUM_REGS; i++)
                    if (w_idx == c_IW'(i)) begin
                        w_data = r_regs[i];
                        w_busy = r_busy[i];
                    end
                if ((BYPASS != 0) && (w_idx != '0))
                    for (int j = 0; j < NUM_WR; j++)
                        if (wr_en[j] && (w_wr_idx[j] == w_idx)) begin
                            w_data = wr_data[j*c_DW +: c_DW];
                            w_fwd  = 1'b1;
                        end
            end

            assign rd_data[g*c_DW +: c_DW] = w_data;
            assign rd_busy[g]              = w_busy & ~w_fwd;
        end
    endgenerate

    assign busy_vec    = r_busy;
    assign wr_conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_ternary_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ternary_regfile_sb
// Brief    : Self-checking bench for ternary_regfile_sb (bypass and no-bypass builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ternary_regfile_sb;

    localparam int NRD  = 4;
    localparam int NWR  = 2;
    localparam int DW   = 54;
    localparam int AW   = 4;
    localparam int NR_A = 9;
    localparam int NR_B = 5;

    localparam logic [3:0] A0 = 4'b0000, A2 = 4'b0010, A3 = 4'b0100, A4 = 4'b0101;
    localparam logic [3:0] A5 = 4'b0110, A7 = 4'b1001, A8 = 4'b1010, AX = 4'b1111;
    localparam logic [DW-1:0] DZ = '0;
    localparam logic [DW-1:0] DA = {27{2'b01}};
    localparam logic [DW-1:0] DB = {27{2'b10}};
    localparam logic [DW-1:0] DC = {9{6'b011000}};

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*DW-1:0]   rd_data_a, rd_data_b;
    logic [NRD-1:0]      rd_busy_a, rd_busy_b;
    logic [NWR-1:0]      wr_en, claim_en;
    logic [NWR*AW-1:0]   wr_addr, claim_addr;
    logic [NWR*DW-1:0]   wr_data;
    logic                flush;
    logic [NR_A-1:0]     busy_vec_a;
    logic [NR_B-1:0]     busy_vec_b;
    logic                wr_conflict_a, wr_conflict_b;

    always #5 clk = ~clk;

    ternary_regfile_sb #(.ADDR_TRITS(2), .NUM_REGS(NR_A), .TRIT_WIDTH(27),
                         .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush),
        .busy_vec(busy_vec_a), .wr_conflict(wr_conflict_a));

    ternary_regfile_sb #(.ADDR_TRITS(2), .NUM_REGS(NR_B), .TRIT_WIDTH(27),
                         .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush),
        .busy_vec(busy_vec_b), .wr_conflict(wr_conflict_b));

    // Reference state for both builds: [0] = bypass/9 regs, [1] = no bypass/5 regs
    logic [DW-1:0] m_regs [2][9];
    logic          m_busy [2][9];
    logic          m_conf [2];
    int            n_tot = 0;
    int            n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nregs(input int inst);
        return (inst == 0) ? NR_A : NR_B;
    endfunction

    function automatic int dec(input logic [3:0] a, input int nr);
        int v;
        int wt;
        v  = 0;
        wt = 1;
        for (int k = 0; k < 2; k++) begin
            if (a[2*k +: 2] == 2'b01) v = v + wt;
            else if (a[2*k +: 2] == 2'b10) v = v + 2 * wt;
            wt = wt * 3;
        end
        return (v >= nr) ? 0 : v;
    endfunction

    function automatic logic [3:0] enc(input int i);
        logic [3:0] r;
        int d0;
        int d1;
        d0 = i % 3;
        d1 = (i / 3) % 3;
        r[1:0] = (d0 == 1) ? 2'b01 : (d0 == 2) ? 2'b10 : 2'b00;
        r[3:2] = (d1 == 1) ? 2'b01 : (d1 == 2) ? 2'b10 : 2'b00;
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic check_reads();
        for (int inst = 0; inst < 2; inst++)
            for (int p = 0; p < NRD; p++) begin
                int            idx;
                logic [DW-1:0] ed;
                logic [DW-1:0] ad;
                logic          eb;
                logic          ab;
                idx = dec(rd_addr[p*AW +: AW], nregs(inst));
                ed  = '0;
                eb  = 1'b0;
                if (idx != 0) begin
                    ed = m_regs[inst][idx];
                    eb = m_busy[inst][idx];
                    if (inst == 0)
                        for (int w = 0; w < NWR; w++)
                            if (wr_en[w] && dec(wr_addr[w*AW +: AW], nregs(inst)) == idx) begin
                                ed = wr_data[w*DW +: DW];
                                eb = 1'b0;
                            end
                end
                ad = (inst == 0) ? rd_data_a[p*DW +: DW] : rd_data_b[p*DW +: DW];
                ab = (inst == 0) ? rd_busy_a[p] : rd_busy_b[p];
                chk($sformatf("rd_data dut%0d port%0d", inst, p), 64'(ad), 64'(ed));
                chk($sformatf("rd_busy dut%0d port%0d", inst, p), 64'(ab), 64'(eb));
            end
    endtask

    task automatic model_step();
        for (int inst = 0; inst < 2; inst++) begin
            int n;
            int ia [2];
            int ic [2];
            n = nregs(inst);
            if (!rst_n) begin
                for (int i = 0; i < 9; i++) begin
                    m_regs[inst][i] = '0;
                    m_busy[inst][i] = 1'b0;
                end
                m_conf[inst] = 1'b0;
            end else begin
                for (int w = 0; w < NWR; w++) begin
                    ia[w] = dec(wr_addr[w*AW +: AW], n);
                    ic[w] = dec(claim_addr[w*AW +: AW], n);
                end
                m_conf[inst] = (wr_en == 2'b11) && (ia[0] == ia[1]) && (ia[0] != 0);
                for (int w = 0; w < NWR; w++)
                    if (wr_en[w] && ia[w] != 0)
                        m_regs[inst][ia[w]] = wr_data[w*DW +: DW];
                for (int i = 1; i < n; i++) begin
                    if (flush)
                        m_busy[inst][i] = 1'b0;
                    else if ((claim_en[0] && ic[0] == i) || (claim_en[1] && ic[1] == i))
                        m_busy[inst][i] = 1'b1;
                    else if ((wr_en[0] && ia[0] == i) || (wr_en[1] && ia[1] == i))
                        m_busy[inst][i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_state();
        logic [NR_A-1:0] eva;
        logic [NR_B-1:0] evb;
        for (int i = 0; i < NR_A; i++) eva[i] = m_busy[0][i];
        for (int i = 0; i < NR_B; i++) evb[i] = m_busy[1][i];
        chk("busy_vec dut0", 64'(busy_vec_a), 64'(eva));
        chk("busy_vec dut1", 64'(busy_vec_b), 64'(evb));
        chk("wr_conflict dut0", 64'(wr_conflict_a), 64'(m_conf[0]));
        chk("wr_conflict dut1", 64'(wr_conflict_b), 64'(m_conf[1]));
    endtask

    task automatic cyc_pre();
        #2;
        check_reads();
        model_step();
    endtask

    task automatic cyc_post();
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle();
        rst_n      = 1'b1;
        wr_en      = '0;
        claim_en   = '0;
        flush      = 1'b0;
        wr_addr    = '0;
        claim_addr = '0;
        wr_data    = '0;
    endtask

    typedef struct {
        logic [1:0]    we;
        logic [3:0]    wa0, wa1;
        logic [DW-1:0] d0, d1;
        logic [1:0]    ce;
        logic [3:0]    ca0, ca1;
        logic          fl;
        logic [3:0]    ra0;
        logic [DW-1:0] exp_rd;
        logic          exp_rb;
        logic [8:0]    exp_bv;
        logic          exp_cf;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{2'b01, A5, A0, DA, DZ, 2'b00, A0, A0, 1'b0, A5, DA, 1'b0, 9'h000, 1'b0};
        tbl[1]  = '{2'b00, A0, A0, DZ, DZ, 2'b00, A0, A0, 1'b0, A5, DA, 1'b0, 9'h000, 1'b0};
        tbl[2]  = '{2'b11, A3, A3, DA, DB, 2'b00, A0, A0, 1'b0, A3, DB, 1'b0, 9'h000, 1'b1};
        tbl[3]  = '{2'b00, A0, A0, DZ, DZ, 2'b00, A0, A0, 1'b0, A3, DB, 1'b0, 9'h000, 1'b0};
        tbl[4]  = '{2'b00, A0, A0, DZ, DZ, 2'b01, A4, A0, 1'b0, A4, DZ, 1'b0, 9'h010, 1'b0};
        tbl[5]  = '{2'b00, A0, A0, DZ, DZ, 2'b00, A0, A0, 1'b0, A4, DZ, 1'b1, 9'h010, 1'b0};
        tbl[6]  = '{2'b01, A4, A0, DC, DZ, 2'b00, A0, A0, 1'b0, A4, DC, 1'b0, 9'h000, 1'b0};
        tbl[7]  = '{2'b01, A4, A0, DA, DZ, 2'b01, A4, A0, 1'b0, A4, DA, 1'b0, 9'h010, 1'b0};
        tbl[8]  = '{2'b00, A0, A0, DZ, DZ, 2'b00, A0, A0, 1'b0, A4, DA, 1'b1, 9'h010, 1'b0};
        tbl[9]  = '{2'b00, A0, A0, DZ, DZ, 2'b11, A7, A8, 1'b0, A7, DZ, 1'b0, 9'h190, 1'b0};
        tbl[10] = '{2'b00, A0, A0, DZ, DZ, 2'b00, A0, A0, 1'b1, A8, DZ, 1'b1, 9'h000, 1'b0};
        tbl[11] = '{2'b11, A0, AX, DA, DB, 2'b11, A0, AX, 1'b0, A0, DZ, 1'b0, 9'h000, 1'b0};
        tbl[12] = '{2'b00, A0, A0, DZ, DZ, 2'b00, A0, A0, 1'b0, AX, DZ, 1'b0, 9'h000, 1'b0};

        for (int inst = 0; inst < 2; inst++) begin
            for (int i = 0; i < 9; i++) begin
                m_regs[inst][i] = '0;
                m_busy[inst][i] = 1'b0;
            end
            m_conf[inst] = 1'b0;
        end

        idle();
        rst_n   = 1'b0;
        rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy_vec", 64'(busy_vec_a), 64'(0));
        chk("reset wr_conflict", 64'(wr_conflict_a), 64'(0));
        idle();

        for (int i = 1; i < NR_A; i++) begin
            rd_addr = {4{enc(i)}};
            cyc_pre();
            chk($sformatf("reset read R%0d", i), 64'(rd_data_a), 64'(0));
            chk($sformatf("reset rd_busy R%0d", i), 64'(rd_busy_a), 64'(0));
            cyc_post();
        end

        for (int v = 0; v < 13; v++) begin
            idle();
            wr_en      = tbl[v].we;
            wr_addr    = {tbl[v].wa1, tbl[v].wa0};
            wr_data    = {tbl[v].d1, tbl[v].d0};
            claim_en   = tbl[v].ce;
            claim_addr = {tbl[v].ca1, tbl[v].ca0};
            flush      = tbl[v].fl;
            rd_addr    = {4{tbl[v].ra0}};
            cyc_pre();
            chk($sformatf("tbl%0d rd_data", v), 64'(rd_data_a[DW-1:0]), 64'(tbl[v].exp_rd));
            chk($sformatf("tbl%0d rd_busy", v), 64'(rd_busy_a[0]), 64'(tbl[v].exp_rb));
            cyc_post();
            chk($sformatf("tbl%0d busy_vec", v), 64'(busy_vec_a), 64'(tbl[v].exp_bv));
            chk($sformatf("tbl%0d wr_conflict", v), 64'(wr_conflict_a), 64'(tbl[v].exp_cf));
        end

        // No-bypass build sees a write only after the edge
        idle();
        wr_en   = 2'b01;
        wr_addr = {A0, A2};
        wr_data = {DZ, DB};
        rd_addr = {4{A2}};
        cyc_pre();
        chk("nobypass same-cycle read", 64'(rd_data_b[DW-1:0]), 64'(0));
        chk("bypass same-cycle read", 64'(rd_data_a[DW-1:0]), 64'(DB));
        cyc_post();
        idle();
        cyc_pre();
        chk("nobypass next-cycle read", 64'(rd_data_b[DW-1:0]), 64'(DB));
        cyc_post();

        // Reset in the middle of live traffic
        idle();
        claim_en   = 2'b11;
        claim_addr = {enc(2), enc(1)};
        cyc_pre();
        cyc_post();
        chk("pre-reset busy", 64'(busy_vec_a), 64'(9'h006));
        idle();
        rst_n      = 1'b0;
        wr_en      = 2'b11;
        wr_addr    = {A3, A5};
        wr_data    = {DC, DC};
        claim_en   = 2'b11;
        claim_addr = {enc(6), enc(4)};
        cyc_pre();
        cyc_post();
        chk("midreset busy_vec", 64'(busy_vec_a), 64'(0));
        chk("midreset wr_conflict", 64'(wr_conflict_a), 64'(0));
        idle();
        rd_addr = {enc(4), enc(2), enc(3), enc(5)};
        cyc_pre();
        chk("midreset rd_data", 64'(rd_data_a[2*DW-1:0]), 64'(0));
        chk("midreset rd_data hi", 64'(rd_data_a[4*DW-1:2*DW]), 64'(0));
        chk("midreset rd_busy", 64'(rd_busy_a), 64'(0));
        cyc_post();

        for (int c = 0; c < 400; c++) begin
            rst_n      = ($urandom_range(0, 49) != 0);
            wr_en      = 2'($urandom_range(0, 3));
            wr_addr    = 8'($urandom_range(0, 255));
            wr_data    = {rnd_data(), rnd_data()};
            claim_en   = 2'($urandom_range(0, 3));
            claim_addr = 8'($urandom_range(0, 255));
            flush      = ($urandom_range(0, 19) == 0);
            rd_addr    = 16'($urandom_range(0, 65535));
            cyc_pre();
            cyc_post();
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
